// File: rtl/rr_arbiter_8.sv
// Round-robin arbiter for 8 requesters with registered one-hot grant,
// bounded hold time (MAX_HOLD) and a mandatory idle cycle between owners.
module rr_arbiter_8 #(
    parameter int MAX_HOLD = 16,
    parameter int CNT_W    = 5
) (
    input  logic       Clk,
    input  logic       Rst_n,
    input  logic       E,
    input  logic [7:0] Req,
    input  logic       Done,
    output logic [7:0] Grant,
    output logic [2:0] Grant_Idx,
    output logic       Valid,
    output logic       Timeout
);

    typedef enum logic {S_IDLE = 1'b0, S_BUSY = 1'b1} state_t;

    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(MAX_HOLD - 1);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [2:0]       r_ptr;
    logic [2:0]       w_ptr_nxt;
    logic [2:0]       r_idx;
    logic [2:0]       w_idx_nxt;
    logic [7:0]       r_grant;
    logic [7:0]       w_grant_nxt;
    logic             r_valid;
    logic             w_valid_nxt;
    logic             r_timeout;
    logic             w_timeout_nxt;

    logic [7:0]       w_rot;
    logic [2:0]       w_offs;
    logic [2:0]       w_winner;
    logic             w_arb;
    logic             w_rel_done;
    logic             w_rel_drop;
    logic             w_rel_lim;
    logic             w_release;

    // Rotate requests so bit 0 is the highest-priority slot, then take the lowest set bit.
    assign w_rot = 8'({Req, Req} >> r_ptr);

    always_comb begin
        w_offs = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (w_rot[i]) w_offs = 3'(i);
        end
    end

    assign w_winner   = r_ptr + w_offs;
    assign w_arb      = (r_state == S_IDLE) && E && (|Req);
    assign w_rel_done = Done;
    assign w_rel_drop = ~Req[r_idx];
    assign w_rel_lim  = (r_cnt == LIMIT);
    assign w_release  = (r_state == S_BUSY) && (w_rel_done || w_rel_drop || w_rel_lim);

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_ptr     <= 3'd0;
            r_idx     <= 3'd0;
            r_grant   <= 8'h00;
            r_valid   <= 1'b0;
            r_timeout <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_ptr     <= w_ptr_nxt;
            r_idx     <= w_idx_nxt;
            r_grant   <= w_grant_nxt;
            r_valid   <= w_valid_nxt;
            r_timeout <= w_timeout_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (r_state == S_IDLE) begin
            if (w_arb) w_state_nxt = S_BUSY;
        end else begin
            if (w_release) w_state_nxt = S_IDLE;
        end
    end

    always_comb begin
        w_cnt_nxt     = r_cnt;
        w_ptr_nxt     = r_ptr;
        w_idx_nxt     = r_idx;
        w_grant_nxt   = r_grant;
        w_valid_nxt   = r_valid;
        w_timeout_nxt = 1'b0;
        if (r_state == S_IDLE) begin
            if (w_arb) begin
                w_cnt_nxt   = '0;
                w_idx_nxt   = w_winner;
                w_grant_nxt = 8'h01 << w_winner;
                w_valid_nxt = 1'b1;
            end else begin
                w_grant_nxt = 8'h00;
                w_valid_nxt = 1'b0;
            end
        end else if (w_release) begin
            w_grant_nxt   = 8'h00;
            w_valid_nxt   = 1'b0;
            w_ptr_nxt     = r_idx + 3'd1;
            // Flag a timeout only when the hold limit was the sole release cause.
            w_timeout_nxt = w_rel_lim && !w_rel_done && !w_rel_drop;
        end else begin
            w_cnt_nxt = r_cnt + 1'b1;
        end
    end

    assign Grant     = r_grant;
    assign Grant_Idx = r_idx;
    assign Valid     = r_valid;
    assign Timeout   = r_timeout;

endmodule

// File: tb/tb_rr_arbiter_8.sv
// Randomised and directed bench for rr_arbiter_8 against a cycle-level
// behavioural model of owner / priority pointer / hold time.
module tb_rr_arbiter_8;

    localparam int MAX_HOLD = 16;

    logic       Clk;
    logic       Rst_n;
    logic       E;
    logic [7:0] Req;
    logic       Done;
    logic [7:0] Grant;
    logic [2:0] Grant_Idx;
    logic       Valid;
    logic       Timeout;

    int n_checks;
    int n_errors;

    // Reference model state
    bit m_busy;
    int m_owner;
    int m_hold;
    int m_ptr;
    bit m_to;

    rr_arbiter_8 #(.MAX_HOLD(MAX_HOLD), .CNT_W(5)) dut (
        .Clk       (Clk),
        .Rst_n     (Rst_n),
        .E         (E),
        .Req       (Req),
        .Done      (Done),
        .Grant     (Grant),
        .Grant_Idx (Grant_Idx),
        .Valid     (Valid),
        .Timeout   (Timeout)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    function automatic logic [12:0] exp_vec();
        logic [7:0] g;
        logic [2:0] ix;
        g  = m_busy ? 8'(1 << m_owner) : 8'h00;
        ix = m_busy ? 3'(m_owner) : 3'd0;
        return {g, m_busy, ix, m_to};
    endfunction

    function automatic logic [12:0] obs_vec();
        return {Grant, Valid, (Valid ? Grant_Idx : 3'd0), Timeout};
    endfunction

    task automatic model_reset();
        m_busy  = 1'b0;
        m_owner = 0;
        m_hold  = 0;
        m_ptr   = 0;
        m_to    = 1'b0;
    endtask

    task automatic apply_reset();
        Rst_n = 1'b0;
        E     = 1'b0;
        Req   = 8'h00;
        Done  = 1'b0;
        model_reset();
        @(posedge Clk);
        #1;
        Rst_n = 1'b1;
    endtask

    // Advance one clock: predict from the arbitration rules, then sample #1 after the edge.
    task automatic tick();
        bit n_busy  = m_busy;
        int n_owner = m_owner;
        int n_hold  = m_hold;
        int n_ptr   = m_ptr;
        bit n_to    = 1'b0;
        bit dn, dr, lim;
        if (!m_busy) begin
            if (E && Req != 8'h00) begin
                for (int k = 0; k < 8; k++) begin
                    if (Req[3'((m_ptr + k) % 8)]) begin
                        n_owner = (m_ptr + k) % 8;
                        break;
                    end
                end
                n_busy = 1'b1;
                n_hold = 0;
            end
        end else begin
            dn  = Done;
            dr  = !Req[3'(m_owner)];
            lim = (m_hold == MAX_HOLD - 1);
            if (dn || dr || lim) begin
                n_busy = 1'b0;
                n_ptr  = (m_owner + 1) % 8;
                n_to   = lim && !dn && !dr;
            end else begin
                n_hold = m_hold + 1;
            end
        end
        @(posedge Clk);
        #1;
        m_busy  = n_busy;
        m_owner = n_owner;
        m_hold  = n_hold;
        m_ptr   = n_ptr;
        m_to    = n_to;
    endtask

    task automatic test_reset();
        logic [12:0] e;
        apply_reset();
        n_checks++;
        e = exp_vec();
        if (obs_vec() !== e) begin
            n_errors++;
            $display("FAIL reset_idle: got %h, expected %h", obs_vec(), e);
        end
        E = 1'b1; Req = 8'h20;
        tick();
        Done = 1'b1;
        tick();
        Done = 1'b0; Req = 8'h40;
        tick();
        n_checks++;
        e = exp_vec();
        if (obs_vec() !== e) begin
            n_errors++;
            $display("FAIL reset_pre_grant: got %h, expected %h", obs_vec(), e);
        end
        #2;
        Rst_n = 1'b0;
        #1;
        n_checks++;
        if ({Grant, Valid, Grant_Idx, Timeout} !== 13'h0000) begin
            n_errors++;
            $display("FAIL reset_async: got G=%h V=%b I=%0d T=%b, expected all zero",
                     Grant, Valid, Grant_Idx, Timeout);
        end
        model_reset();
        @(posedge Clk);
        #1;
        Rst_n = 1'b1;
        Req   = 8'h41;
        tick();
        n_checks++;
        if (Grant !== 8'h01 || obs_vec() !== exp_vec()) begin
            n_errors++;
            $display("FAIL reset_ptr: got G=%h, expected G=01 (model %h)", Grant, exp_vec());
        end
    endtask

    task automatic test_single();
        logic [7:0] req_seq [4] = '{8'h04, 8'h04, 8'h09, 8'h00};
        bit         dn_seq  [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
        apply_reset();
        E = 1'b1;
        for (int i = 0; i < 4; i++) begin
            Req  = req_seq[i];
            Done = dn_seq[i];
            tick();
            n_checks++;
            if (obs_vec() !== exp_vec()) begin
                n_errors++;
                $display("FAIL single step %0d: got %h, expected %h", i, obs_vec(), exp_vec());
            end
        end
        Done = 1'b0;
        tick();
    endtask

    task automatic test_rotation();
        bit prev_v = 1'b0;
        int g = 0;
        apply_reset();
        E = 1'b1; Req = 8'hFF;
        for (int c = 0; c < 60; c++) begin
            Done = (c % 3 == 2);
            tick();
            n_checks++;
            if (obs_vec() !== exp_vec()) begin
                n_errors++;
                $display("FAIL rotation cyc %0d: got %h, expected %h", c, obs_vec(), exp_vec());
            end
            if (Valid && !prev_v) begin
                if (g < 9) begin
                    n_checks++;
                    if (Grant_Idx !== 3'(g % 8)) begin
                        n_errors++;
                        $display("FAIL rotation_order grant %0d: got idx %0d, expected %0d",
                                 g, Grant_Idx, g % 8);
                    end
                end
                g++;
            end
            prev_v = Valid;
        end
        n_checks++;
        if (g < 9) begin
            n_errors++;
            $display("FAIL rotation_count: got %0d grants, expected at least 9", g);
        end
        Done = 1'b0; Req = 8'h00;
        tick();
        tick();
    endtask

    task automatic test_timeout();
        int held = 0;
        apply_reset();
        E = 1'b1; Req = 8'h80;
        for (int i = 0; i < 17; i++) begin
            tick();
            n_checks++;
            if (obs_vec() !== exp_vec()) begin
                n_errors++;
                $display("FAIL timeout cyc %0d: got %h, expected %h", i, obs_vec(), exp_vec());
            end
            if (Grant == 8'h80) held++;
        end
        n_checks++;
        if (held != MAX_HOLD || Timeout !== 1'b1 || Grant !== 8'h00) begin
            n_errors++;
            $display("FAIL timeout_pulse: got held=%0d T=%b G=%h, expected held=%0d T=1 G=00",
                     held, Timeout, Grant, MAX_HOLD);
        end
        Req = 8'h81;
        tick();
        n_checks++;
        if (Grant !== 8'h01 || Timeout !== 1'b0 || obs_vec() !== exp_vec()) begin
            n_errors++;
            $display("FAIL timeout_wrap: got G=%h T=%b, expected G=01 T=0", Grant, Timeout);
        end
        Done = 1'b1;
        tick();
        Done = 1'b0; Req = 8'h00;
        tick();
    endtask

    task automatic test_enable();
        bit e_seq [12] = '{0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0};
        bit d_seq [12] = '{0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0};
        apply_reset();
        Req = 8'h11;
        for (int i = 0; i < 12; i++) begin
            E    = e_seq[i];
            Done = d_seq[i];
            tick();
            n_checks++;
            if (obs_vec() !== exp_vec()) begin
                n_errors++;
                $display("FAIL enable step %0d: got %h, expected %h", i, obs_vec(), exp_vec());
            end
        end
        Done = 1'b0;
    endtask

    task automatic test_drop();
        apply_reset();
        E = 1'b1;
        // Owner drops request mid-grant.
        Req = 8'h02;
        tick(); tick();
        Req = 8'h00;
        tick();
        n_checks++;
        if (Grant !== 8'h00 || Timeout !== 1'b0 || obs_vec() !== exp_vec()) begin
            n_errors++;
            $display("FAIL drop_release: got G=%h T=%b, expected G=00 T=0", Grant, Timeout);
        end
        // Done coincides with the hold limit, then request drop coincides with it.
        for (int pass = 0; pass < 2; pass++) begin
            Req = 8'h02;
            for (int i = 0; i < MAX_HOLD; i++) begin
                tick();
                n_checks++;
                if (obs_vec() !== exp_vec()) begin
                    n_errors++;
                    $display("FAIL drop_hold pass %0d cyc %0d: got %h, expected %h",
                             pass, i, obs_vec(), exp_vec());
                end
            end
            if (pass == 0) Done = 1'b1;
            else           Req  = 8'h00;
            tick();
            n_checks++;
            if (Grant !== 8'h00 || Timeout !== 1'b0 || obs_vec() !== exp_vec()) begin
                n_errors++;
                $display("FAIL drop_limit pass %0d: got G=%h T=%b, expected G=00 T=0",
                         pass, Grant, Timeout);
            end
            Done = 1'b0; Req = 8'h00;
            tick();
        end
    endtask

    task automatic test_random();
        apply_reset();
        for (int c = 0; c < 600; c++) begin
            Req  = ($urandom_range(0, 5) == 0) ? 8'h00 : 8'($urandom);
            E    = ($urandom_range(0, 6) != 0);
            Done = ($urandom_range(0, 4) == 0);
            tick();
            n_checks++;
            if (obs_vec() !== exp_vec()) begin
                n_errors++;
                $display("FAIL random cyc %0d: got %h, expected %h", c, obs_vec(), exp_vec());
            end
        end
        // Long holds: owner keeps its request, others churn.
        for (int c = 0; c < 300; c++) begin
            if (m_busy) Req = 8'($urandom) | 8'(1 << m_owner);
            else        Req = 8'($urandom);
            E    = 1'b1;
            Done = ($urandom_range(0, 24) == 0);
            tick();
            n_checks++;
            if (obs_vec() !== exp_vec()) begin
                n_errors++;
                $display("FAIL random_hold cyc %0d: got %h, expected %h", c, obs_vec(), exp_vec());
            end
        end
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        Rst_n    = 1'b0;
        E        = 1'b0;
        Req      = 8'h00;
        Done     = 1'b0;
        model_reset();
        #12;
        test_reset();
        test_single();
        test_rotation();
        test_timeout();
        test_enable();
        test_drop();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
